// File: rtl/inst_sched_pf.sv
// inst_sched_pf: prefetching instruction scheduler dispatching CALC/DMA/SYNC/JUMP/END
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_start_npu, i_stop_npu              start pulse (honoured in IDLE), abort pulse (any state)
//   o_pc, o_instb_rd_en                  fetch address and request; data returns one cycle later
//   i_inst_in, i_inst_valid              returned instruction and its strobe
//   o_inst, o_inst_issue                 dispatched instruction (held) and its one-cycle issue pulse
//   o_calculate_enable, i_calculate_end  CALC run level and completion pulse
//   o_ex_dma, o_dma_noblock              DMA launch pulse and its non-blocking qualifier
//   i_dma_finish, o_nb_dma_cnt           DMA completion pulse and outstanding DMA count
//   o_npu_idle, o_internal_stop          idle status, END/error termination pulse
//   o_err_inst                           sticky illegal-opcode flag, cleared on start
module inst_sched_pf #(
    parameter int PC_W       = 12,
    parameter int INST_W     = 128,
    parameter int PF_DEPTH   = 4,
    parameter int MAX_NB_DMA = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start_npu,
    input  logic              i_stop_npu,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_instb_rd_en,
    input  logic [INST_W-1:0] i_inst_in,
    input  logic              i_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_issue,
    output logic              o_calculate_enable,
    input  logic              i_calculate_end,
    output logic              o_ex_dma,
    output logic              o_dma_noblock,
    input  logic              i_dma_finish,
    output logic [3:0]        o_nb_dma_cnt,
    output logic              o_npu_idle,
    output logic              o_internal_stop,
    output logic              o_err_inst
);
    localparam int AW = $clog2(PF_DEPTH);
    localparam logic [AW+1:0] DEPTH = (AW+2)'(PF_DEPTH);
    localparam logic [3:0] MAX_DMA = 4'(MAX_NB_DMA);
    localparam logic [4:0] OP_NOP = 5'h00, OP_CALC = 5'h01, OP_DMA = 5'h02,
                           OP_JUMP = 5'h03, OP_SYNC = 5'h04, OP_END = 5'h1F;

    typedef enum logic [2:0] {IDLE, FETCH, CALC_WAIT, DMA_WAIT, SYNC_WAIT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] q_mem [PF_DEPTH];
    logic [AW-1:0]     rp_q, rp_d, wp_q, wp_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              inflight_q, discard_q;
    logic [3:0]        dma_q, dma_d;
    logic              err_q, err_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              issue_q, issue_d, ex_q, ex_d, nbo_q, nbo_d, stop_q, stop_d;
    logic [INST_W-1:0] head;
    logic [4:0]        op;
    logic              nb, active, pop, flush, push, rd_en;

    assign head   = q_mem[rp_q];
    assign op     = head[INST_W-1 -: 5];
    assign nb     = head[INST_W-6];
    assign active = state_q != IDLE;
    // A DMA at the head waits in the queue while every DMA slot is taken.
    assign pop    = state_q == FETCH && cnt_q != '0 && !i_stop_npu && !(op == OP_DMA && dma_q == MAX_DMA);
    assign flush  = i_stop_npu || (pop && !(op inside {OP_NOP, OP_CALC, OP_DMA, OP_SYNC}));
    // Requests already in flight are counted so the queue can never overflow.
    assign rd_en  = active && !flush && ({1'b0, cnt_q} + {{(AW+1){1'b0}}, inflight_q}) < DEPTH;
    // A return landing in a flush cycle or the cycle after belongs to the discarded stream.
    assign push   = i_inst_valid && active && !flush && !discard_q;

    always_comb begin
        rp_d  = flush ? '0 : rp_q + AW'(pop);
        wp_d  = flush ? '0 : wp_q + AW'(push);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = rd_en ? pc_q + 1'b1 : pc_q;
        err_d   = err_q;
        inst_d  = inst_q;
        issue_d = 1'b0;
        ex_d    = 1'b0;
        nbo_d   = 1'b0;
        stop_d  = 1'b0;
        case (state_q)
            IDLE: if (i_start_npu && !i_stop_npu) begin
                state_d = FETCH;
                pc_d    = '0;
                err_d   = 1'b0;
            end
            FETCH: if (pop) begin
                issue_d = 1'b1;
                inst_d  = head;
                case (op)
                    OP_NOP: ;
                    OP_CALC: state_d = CALC_WAIT;
                    OP_DMA: begin
                        ex_d    = 1'b1;
                        nbo_d   = nb;
                        state_d = nb ? FETCH : DMA_WAIT;
                    end
                    OP_SYNC: state_d = dma_q != '0 ? SYNC_WAIT : FETCH;
                    OP_JUMP: pc_d = head[PC_W-1:0];
                    OP_END: begin
                        stop_d  = 1'b1;
                        state_d = IDLE;
                    end
                    default: begin
                        err_d   = 1'b1;
                        stop_d  = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            CALC_WAIT: state_d = i_calculate_end ? FETCH : CALC_WAIT;
            DMA_WAIT, SYNC_WAIT: state_d = dma_q == '0 ? FETCH : state_q;
            default: state_d = IDLE;
        endcase
        if (i_stop_npu) state_d = IDLE;
        dma_d = i_stop_npu ? '0 : dma_q + 4'(ex_d) - 4'(i_dma_finish && dma_q != '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            rp_q       <= '0;
            wp_q       <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            dma_q      <= '0;
            err_q      <= 1'b0;
            inst_q     <= '0;
            issue_q    <= 1'b0;
            ex_q       <= 1'b0;
            nbo_q      <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            inflight_q <= rd_en;
            discard_q  <= flush;
            dma_q      <= dma_d;
            err_q      <= err_d;
            inst_q     <= inst_d;
            issue_q    <= issue_d;
            ex_q       <= ex_d;
            nbo_q      <= nbo_d;
            stop_q     <= stop_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) q_mem[wp_q] <= i_inst_in;
    end

    assign o_pc               = pc_q;
    assign o_instb_rd_en      = rd_en;
    assign o_inst             = inst_q;
    assign o_inst_issue       = issue_q;
    assign o_calculate_enable = state_q == CALC_WAIT;
    assign o_ex_dma           = ex_q;
    assign o_dma_noblock      = nbo_q;
    assign o_nb_dma_cnt       = dma_q;
    assign o_npu_idle         = state_q == IDLE;
    assign o_internal_stop    = stop_q;
    assign o_err_inst         = err_q;
endmodule
